// File: rtl/sr_ff_bank.sv
// sr_ff_bank: bank of WIDTH independent clocked set/reset flip-flops.
// Build-time options choose how a coincident set+reset resolves
// (CONFLICT_MODE), level vs rising-edge requests (EDGE_MODE) and an
// optional auto-clear after TIMEOUT idle cycles high.
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst          synchronous active-high reset
//   S, R         per-channel set / reset requests
//   clr_err      clears err_sticky (a same-cycle conflict wins)
//   Q, Q_bar     registered channel state and its complement
//   conflict     per-channel pulse: effective set and reset coincided
//   timeout_evt  per-channel pulse: channel auto-cleared
//   err_sticky   any conflict seen since last clr_err / reset

// One channel. hit is the unregistered effective s&r, fed to the
// bank-level sticky error so it can react on the same edge.
module sr_ff_cell #(
  parameter int   CONFLICT_MODE = 0,
  parameter int   EDGE_MODE     = 0,
  parameter int   TIMEOUT       = 0,
  parameter logic RST_Q         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s_in,
  input  logic r_in,
  output logic q,
  output logic conflict,
  output logic timeout_evt,
  output logic hit
);
  logic s, r;
  logic q_res, set_wr, q_nxt;

  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic s_prev, r_prev;
      // Tracked through reset too, so inputs held high across reset
      // do not look like a fresh edge afterwards.
      always_ff @(posedge clk) begin
        s_prev <= s_in;
        r_prev <= r_in;
      end
      assign s = s_in & ~s_prev;
      assign r = r_in & ~r_prev;
    end else begin : g_lvl
      assign s = s_in;
      assign r = r_in;
    end
  endgenerate

  assign hit = s & r;

  // set_wr marks every path that writes a 1 through a set, which is
  // what restarts the timeout count.
  always_comb begin
    q_res  = q;
    set_wr = 1'b0;
    case ({s, r})
      2'b10: begin q_res = 1'b1; set_wr = 1'b1; end
      2'b01: q_res = 1'b0;
      2'b11: begin
        case (CONFLICT_MODE)
          0:       q_res = 1'b0;
          1:       begin q_res = 1'b1; set_wr = 1'b1; end
          2:       q_res = q;
          default: begin q_res = ~q; set_wr = ~q; end
        endcase
      end
      default: ;
    endcase
  end

  generate
    if (TIMEOUT > 0) begin : g_to
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;
      logic          idle_hi, expire;

      // Any request (including a holding conflict) suppresses counting.
      assign idle_hi = q & ~s & ~r;
      assign expire  = idle_hi && (cnt == CW'(TIMEOUT - 1));
      assign q_nxt   = expire ? 1'b0 : q_res;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt         <= '0;
          timeout_evt <= 1'b0;
        end else begin
          timeout_evt <= expire;
          if (set_wr || expire) cnt <= '0;
          else if (idle_hi)     cnt <= cnt + CW'(1);
        end
      end
    end else begin : g_no_to
      assign q_nxt       = q_res;
      assign timeout_evt = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= RST_Q;
      conflict <= 1'b0;
    end else begin
      q        <= q_nxt;
      conflict <= hit;
    end
  end
endmodule

module sr_ff_bank #(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = 0,
  parameter int               EDGE_MODE     = 0,
  parameter int               TIMEOUT       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             clr_err,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic [WIDTH-1:0] conflict,
  output logic [WIDTH-1:0] timeout_evt,
  output logic             err_sticky
);
  logic [WIDTH-1:0] hit;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      sr_ff_cell #(
        .CONFLICT_MODE(CONFLICT_MODE),
        .EDGE_MODE    (EDGE_MODE),
        .TIMEOUT      (TIMEOUT),
        .RST_Q        (RESET_VALUE[i])
      ) u_cell (
        .clk        (clk),
        .rst        (rst),
        .s_in       (S[i]),
        .r_in       (R[i]),
        .q          (Q[i]),
        .conflict   (conflict[i]),
        .timeout_evt(timeout_evt[i]),
        .hit        (hit[i])
      );
    end
  endgenerate

  assign Q_bar = ~Q;

  // A conflict on the same edge as clr_err keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) err_sticky <= 1'b0;
    else     err_sticky <= (err_sticky & ~clr_err) | (|hit);
  end
endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: five differently-configured banks share one
// stimulus stream. A behavioural model predicts each bank's outputs
// when stimulus is issued and queues them; a monitor compares after
// each rising edge.
module tb_sr_ff_bank;
  localparam int NC = 5;
  localparam int             CM [NC] = '{0, 1, 2, 3, 0};
  localparam int             EM [NC] = '{0, 0, 1, 0, 1};
  localparam int             TO [NC] = '{0, 4, 4, 0, 1};
  localparam logic [7:0]     RV [NC] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h3C};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] S = '0, R = '0;
  logic clr_err = 1'b0;

  logic [7:0] q_o [NC];
  logic [7:0] qb_o [NC];
  logic [7:0] cf_o [NC];
  logic [7:0] te_o [NC];
  logic       err_o [NC];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NC; g++) begin : g_dut
      sr_ff_bank #(
        .WIDTH(8), .CONFLICT_MODE(CM[g]), .EDGE_MODE(EM[g]),
        .TIMEOUT(TO[g]), .RESET_VALUE(RV[g])
      ) dut (
        .clk(clk), .rst(rst), .S(S), .R(R), .clr_err(clr_err),
        .Q(q_o[g]), .Q_bar(qb_o[g]), .conflict(cf_o[g]),
        .timeout_evt(te_o[g]), .err_sticky(err_o[g])
      );
    end
  endgenerate

  typedef struct packed {
    logic [NC-1:0][7:0] q;
    logic [NC-1:0][7:0] cf;
    logic [NC-1:0][7:0] te;
    logic [NC-1:0]      err;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Model state: channel value, idle cycles spent high since last set,
  // previous raw inputs, sticky error.
  logic [7:0] mq [NC];
  int         mage [NC][8];
  logic [7:0] mps [NC], mpr [NC];
  logic       merr [NC];

  task automatic model_step(input logic rs, input logic [7:0] si,
                            input logic [7:0] ri, input logic cl,
                            output exp_t e);
    for (int c = 0; c < NC; c++) begin
      logic [7:0] cf, te;
      cf = '0; te = '0;
      if (rs) begin
        mq[c] = RV[c];
        merr[c] = 1'b0;
        for (int i = 0; i < 8; i++) mage[c][i] = 0;
      end else begin
        for (int i = 0; i < 8; i++) begin
          bit s, r;
          s = EM[c] ? (si[i] && !mps[c][i]) : si[i];
          r = EM[c] ? (ri[i] && !mpr[c][i]) : ri[i];
          if (s && r) begin
            cf[i] = 1'b1;
            if (CM[c] == 0) mq[c][i] = 1'b0;
            else if (CM[c] == 1) begin mq[c][i] = 1'b1; mage[c][i] = 0; end
            else if (CM[c] == 3) begin
              mq[c][i] = !mq[c][i];
              if (mq[c][i]) mage[c][i] = 0;
            end
          end else if (s) begin
            mq[c][i] = 1'b1; mage[c][i] = 0;
          end else if (r) begin
            mq[c][i] = 1'b0; mage[c][i] = 0;
          end else if (mq[c][i] && TO[c] > 0) begin
            mage[c][i]++;
            if (mage[c][i] == TO[c]) begin
              mq[c][i] = 1'b0; te[i] = 1'b1; mage[c][i] = 0;
            end
          end
        end
        merr[c] = (merr[c] && !cl) || (cf != 0);
      end
      mps[c] = si;
      mpr[c] = ri;
      e.q[c] = mq[c]; e.cf[c] = cf; e.te[c] = te; e.err[c] = merr[c];
    end
  endtask

  task automatic cyc(input logic rs, input logic [7:0] si,
                     input logic [7:0] ri, input logic cl);
    exp_t e;
    @(negedge clk);
    rst = rs; S = si; R = ri; clr_err = cl;
    model_step(rs, si, ri, cl, e);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic chk(input string n, input int c, input logic [7:0] a,
                     input logic [7:0] x);
    vectors++;
    if (a !== x) begin
      miscompares++;
      $display("FAIL d%0d %s got %h expected %h at %0t", c, n, a, x, $time);
    end
  endtask

  // Monitor: one registered result per edge once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int c = 0; c < NC; c++) begin
          chk("Q", c, q_o[c], e.q[c]);
          chk("Q_bar", c, qb_o[c], ~e.q[c]);
          chk("conflict", c, cf_o[c], e.cf[c]);
          chk("timeout_evt", c, te_o[c], e.te[c]);
          chk("err_sticky", c, {7'b0, err_o[c]}, {7'b0, e.err[c]});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired with %0d results pending", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with all requests high, then release with them still high.
    repeat (3) cyc(1'b1, 8'hFF, 8'hFF, 1'b0);
    repeat (3) cyc(1'b0, 8'hFF, 8'hFF, 1'b0);
    cyc(1'b1, 8'h00, 8'hFF, 1'b0);
    cyc(1'b0, 8'h00, 8'hFF, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1);
    // Basic set / hold / reset.
    cyc(1'b0, 8'h01, 8'h00, 1'b0);
    idle(5);
    cyc(1'b0, 8'h00, 8'h01, 1'b0);
    idle(1);
    // Single conflict, held conflict, conflict with clr_err.
    cyc(1'b0, 8'h01, 8'h01, 1'b0);
    idle(2);
    cyc(1'b0, 8'h00, 8'h01, 1'b1);
    idle(1);
    repeat (4) cyc(1'b0, 8'h01, 8'h01, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1);
    cyc(1'b0, 8'h02, 8'h02, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1);
    idle(1);
    // Held set: one set in edge mode, timeout not restarted.
    repeat (10) cyc(1'b0, 8'h01, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 8'hFF, 1'b0);
    idle(1);
    // Timeout: plain, re-set at +2, reset on the expiry cycle.
    cyc(1'b0, 8'h01, 8'h00, 1'b0);
    idle(6);
    cyc(1'b0, 8'h01, 8'h00, 1'b0);
    idle(1);
    cyc(1'b0, 8'h01, 8'h00, 1'b0);
    idle(6);
    cyc(1'b0, 8'h01, 8'h00, 1'b0);
    idle(3);
    cyc(1'b0, 8'h00, 8'h01, 1'b0);
    idle(3);
    // Reset mid-countdown.
    cyc(1'b0, 8'h81, 8'h00, 1'b0);
    idle(2);
    cyc(1'b1, 8'h00, 8'h00, 1'b0);
    idle(6);
    // Random traffic, sparse requests, occasional clr_err / reset.
    for (int k = 0; k < 600; k++) begin
      logic [7:0] si, ri;
      si = 8'($urandom & $urandom);
      ri = 8'($urandom & $urandom & $urandom);
      cyc($urandom_range(0, 99) == 0, si, ri, $urandom_range(0, 7) == 0);
    end
    idle(2);
    @(posedge clk);
    #3;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
